// File: rtl/shake_req_arbiter.sv
// Message-granular round-robin arbiter that shares one shake_top core between
// N_REQ requesters: grants an owner, pulses start, gates its data and routes the result.
module shake_req_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [3*N_REQ-1:0]   req_mode_i,
  input  logic [64*N_REQ-1:0]  req_din_i,
  input  logic [N_REQ-1:0]     req_din_valid_i,
  input  logic [N_REQ-1:0]     req_last_i,
  input  logic [4*N_REQ-1:0]   req_last_byte_i,
  output logic [N_REQ-1:0]     req_din_ready_o,
  input  logic [N_REQ-1:0]     req_dout_ready_i,
  output logic [N_REQ-1:0]     req_dout_valid_o,
  output logic [1343:0]        dout_full_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  output logic [2:0]           core_mode_o,
  output logic                 core_start_o,
  output logic [63:0]          core_din_o,
  output logic                 core_din_valid_o,
  output logic                 core_last_o,
  output logic [3:0]           core_last_byte_o,
  output logic                 core_dout_ready_o,
  output logic                 core_hold_o,
  input  logic [1343:0]        core_dout_i,
  input  logic                 core_dout_valid_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] owner_q, rr_ptr_q, win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic             win_found;
  logic             res_hs;
  int unsigned      cand, own_i, win_i;

  assign dout_full_o = core_dout_i;
  assign core_hold_o = 1'b0;
  assign busy_o      = (state_q != S_IDLE);
  assign own_i       = 32'(owner_q);
  assign win_i       = 32'(win_idx);

  // Search upward from rr_ptr with wrap; first requesting index wins.
  always_comb begin
    win_idx    = '0;
    win_found  = 1'b0;
    win_onehot = '0;
    cand       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % N_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    state_d           = state_q;
    core_start_o      = 1'b0;
    core_din_o        = '0;
    core_din_valid_o  = 1'b0;
    core_last_o       = 1'b0;
    core_last_byte_o  = '0;
    core_dout_ready_o = 1'b0;
    req_din_ready_o   = '0;
    req_dout_valid_o  = '0;
    res_hs            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) state_d = S_START;
      end
      S_START: begin
        core_start_o = 1'b1;
        state_d      = S_DATA;
      end
      S_DATA: begin
        core_din_o             = req_din_i[64*own_i +: 64];
        core_din_valid_o       = req_din_valid_i[own_i];
        core_last_o            = req_last_i[own_i];
        core_last_byte_o       = req_last_byte_i[4*own_i +: 4];
        req_din_ready_o[own_i] = 1'b1;
        if (req_din_valid_i[own_i] && req_last_i[own_i]) state_d = S_WAIT;
      end
      S_WAIT: begin
        core_dout_ready_o       = req_dout_ready_i[own_i];
        req_dout_valid_o[own_i] = core_dout_valid_i;
        res_hs                  = core_dout_valid_i && req_dout_ready_i[own_i];
        if (res_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      grant_o     <= '0;
      core_mode_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && win_found) begin
        owner_q     <= win_idx;
        grant_o     <= win_onehot;
        core_mode_o <= req_mode_i[3*win_i +: 3];
      end
      if (res_hs) begin
        grant_o  <= '0;
        rr_ptr_q <= (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: doc/shake_req_arbiter.md
# shake_req_arbiter

Shares a single `shake_top` hashing core between `N_REQ` independent requesters at message granularity. Each message is a start/mode/data/last sequence followed by a 1344-bit full-width result. The block grants one requester at a time using round-robin, then sequences that requester's message through the core. It issues the one-cycle `start` pulse, gates the data stream, and routes the result and its handshake back to the owner. It sits between the client blocks and `shake_top`, and drives every core input except the clock and reset.

## Interface
- `N_REQ`, 2: number of requesters; legal range 2 to 8.
- `PTR_W`, `$clog2(N_REQ)`: width of the owner index and the round-robin pointer.

- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_i` in N_REQ: per-requester message request, held high until granted.
- `req_mode_i` in 3·N_REQ: per-requester mode, 3 bits per requester, packed with requester `i` at `[3i+2:3i]`.
- `req_din_i` in 64·N_REQ: per-requester data word.
- `req_din_valid_i` in N_REQ: per-requester data valid.
- `req_last_i` in N_REQ: per-requester last-word flag.
- `req_last_byte_i` in 4·N_REQ: number of valid bytes in the last word.
- `req_din_ready_o` out N_REQ: data accepted for requester `i`.
- `req_dout_ready_i` in N_REQ: per-requester result ready.
- `req_dout_valid_o` out N_REQ: result valid for requester `i`.
- `dout_full_o` out 1344: core result, broadcast to all requesters.
- `grant_o` out N_REQ: one-hot current owner.
- `busy_o` out 1: high whenever the state is not IDLE.
- `core_mode_o` out 3: connects to core `mode_i`.
- `core_start_o` out 1: connects to core `start_i`.
- `core_din_o` out 64: connects to core `din_i`.
- `core_din_valid_o` out 1: connects to core `din_valid_i`.
- `core_last_o` out 1: connects to core `last_din_i`.
- `core_last_byte_o` out 4: connects to core `last_din_byte_i`.
- `core_dout_ready_o` out 1: connects to core `dout_ready_i`.
- `core_hold_o` out 1: connects to core `sha3_hold`; held 0 by this block.
- `core_dout_i` in 1344: from core `dout_full_o`.
- `core_dout_valid_i` in 1: from core `dout_full_valid_o`.

## Operation
- FSM states: IDLE, START, DATA, WAIT.
- **IDLE:** if any `req_i` bit is set, select the first set bit searching upward from `rr_ptr`, wrapping past `N_REQ-1` to 0.
  - Register the winner into `owner` and `grant_o`, and latch its mode into `core_mode_o`.
  - Next state is START.
- **START:** `core_start_o`=1 for exactly one cycle. Next state is DATA.
- **DATA:** the owner's input lanes are muxed onto the `core_din*` and `core_last*` outputs.
  - `req_din_ready_o[owner]`=1; all other ready bits are 0.
  - `core_din_valid_o` = owner's valid.
  - On a cycle where owner valid and owner last are both 1, the beat is forwarded and the next state is WAIT.
- **WAIT:** `core_dout_ready_o` = `req_dout_ready_i[owner]`, and `req_dout_valid_o[owner]` = `core_dout_valid_i`.
  - On a cycle where `core_dout_valid_i` and the owner's ready are both 1, the next state is IDLE.
  - On that same transition, `rr_ptr` becomes `owner+1`, or 0 if `owner` equals `N_REQ-1`.
  - `grant_o` clears on the same transition.
- Outside DATA, all `core_din_valid_o`, `core_last_o` and `req_din_ready_o` bits are 0.
- Outside WAIT, `core_dout_ready_o` and all `req_dout_valid_o` bits are 0.
- `dout_full_o` = `core_dout_i` at all times; this path is combinational.
- Ownership rules:
  - Deasserting `req_i[owner]` after the grant has no effect; ownership ends only on the WAIT handshake.
  - Non-owner `din_valid` and `dout_ready` inputs are ignored.
- Reset, whether asserted asynchronously or mid-message:
  - State returns to IDLE, `rr_ptr`=0, `owner`=0.
  - All outputs are 0, including `core_mode_o`=0 and `grant_o`=0.
  - The core is reset by the same `rst_ni`; no partial message survives.

## Timing
- Cycle 0: IDLE sees a request. Cycle 1: START, with `grant_o` and `core_start_o` high. Cycle 2: first cycle of DATA, with the owner's ready high.
- Data beats pass through combinationally with zero added latency. DATA beat gaps (valid=0) are permitted.
- The last beat at cycle k puts the FSM in WAIT at k+1.
- A result handshake at cycle m puts the FSM in IDLE at m+1. The next grant is registered at m+2, so there is a minimum 2-cycle gap between messages.
- The arbitration decision is registered; `grant_o` never changes within a message.

## Test plan
- **Single requester:** `req_i`=01, SHAKE256 (mode 010), two words ending with last, `last_byte`=8.
  - Expect `core_start_o` at cycle 1, both words on `core_din_o`, and `req_dout_valid_o`=01 when the core result is valid.
- **Simultaneous requests:** `req_i`=11 at reset exit.
  - Expect grant 01, then grant 10 after the first result handshake, then grant 01 if both are still requesting.
- **Result backpressure:** hold `req_dout_ready_i[owner]`=0 for 20 cycles in WAIT.
  - Expect the FSM to stay in WAIT with `core_dout_ready_o`=0, and completion on the first cycle ready=1.
- **Non-owner isolation:** requester 1 drives valid, last and data while requester 0 owns the core.
  - Expect `core_din_o` to carry requester 0's data and `req_din_ready_o[1]`=0.
- **Reset mid-DATA:** assert `rst_ni`=0 after the first beat.
  - Expect all outputs at 0 immediately, and arbitration to restart from requester 0.
- **Ownership across mode change:** requester 0 changes `req_mode_i` and drops `req_i` after the grant.
  - Expect `core_mode_o` to keep the latched mode and the message to complete normally.
